// File: rtl/register_bank_pkg.sv
// rtl/register_bank_pkg.sv - shared state encoding and default widths for the register bank
package register_bank_pkg;

  // Two-state sequencer: CLEAR walks the array writing zeros, RUN serves reads/writes.
  typedef enum logic {
    STATE_CLEAR = 1'b0,
    STATE_RUN   = 1'b1
  } state_e;

  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 5;

endpackage

// File: rtl/register_bank_read_port.sv
// rtl/register_bank_read_port.sv - one registered read port with range/zero masking and write bypass
module register_bank_read_port
  import register_bank_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              run_i,
  input  logic [ADDR_W-1:0] read_address_i,
  input  logic [DATA_W-1:0] array_data_i,
  input  logic              write_en_i,
  input  logic [ADDR_W-1:0] write_address_i,
  input  logic [DATA_W-1:0] write_data_i,
  output logic [DATA_W-1:0] read_data_o
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  logic              in_range;
  logic              is_zero_reg;
  logic [DATA_W-1:0] read_data_d;
  logic [DATA_W-1:0] read_data_q;

  assign in_range    = {1'b0, read_address_i} < DEPTH_EXT;
  assign is_zero_reg = (ZERO_REG != 0) && (read_address_i == '0);

  // Select the value for this port: masked zero, then same-cycle write, then stored word.
  always_comb begin
    read_data_d = '0;
    if (!in_range || is_zero_reg) begin
      read_data_d = '0;
    end else if (write_en_i && (write_address_i == read_address_i)) begin
      read_data_d = write_data_i;
    end else begin
      read_data_d = array_data_i;
    end
  end

  // Output register; forced to zero on reset and for every edge spent clearing.
  always_ff @(posedge clock_i) begin
    if (reset_i || !run_i) begin
      read_data_q <= '0;
    end else begin
      read_data_q <= read_data_d;
    end
  end

  assign read_data_o = read_data_q;

endmodule

// File: rtl/register_bank_param.sv
// rtl/register_bank_param.sv - parametrised register bank with clear sequencer and NUM_READ read ports
module register_bank_param
  import register_bank_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       write,
  input  logic [ADDR_W-1:0]          write_address,
  input  logic [DATA_W-1:0]          write_data,
  input  logic [NUM_READ*ADDR_W-1:0] read_address,
  output logic [NUM_READ*DATA_W-1:0] read_data,
  output logic                       ready
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clear_index_q, clear_index_d;

  // Storage has no reset so it can map onto a RAM; the sequencer zeroes it instead.
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [IDX_W-1:0]    mem_idx;
  logic [DATA_W-1:0]   mem_wdata;

  logic                wr_in_range;
  logic                wr_to_zero;
  logic                wr_accept;
  logic                running;

  assign running     = (state_q == STATE_RUN);
  assign wr_in_range = {1'b0, write_address} < DEPTH_EXT;
  assign wr_to_zero  = (ZERO_REG != 0) && (write_address == '0);
  // A clear request in the same cycle discards the write, so it also gets no bypass.
  assign wr_accept   = !reset && running && !clear && write && wr_in_range && !wr_to_zero;

  // Sequencer state and clear counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= STATE_CLEAR;
      clear_index_q <= '0;
    end else begin
      state_q       <= state_d;
      clear_index_q <= clear_index_d;
    end
  end

  // Next state and the single array write port, shared by the clear walk and normal writes.
  always_comb begin
    state_d       = state_q;
    clear_index_d = clear_index_q;
    mem_we        = 1'b0;
    mem_idx       = write_address[IDX_W-1:0];
    mem_wdata     = write_data;
    case (state_q)
      STATE_CLEAR: begin
        mem_we    = !reset;
        mem_idx   = clear_index_q[IDX_W-1:0];
        mem_wdata = '0;
        if (clear_index_q == LAST_IDX) begin
          state_d       = STATE_RUN;
          clear_index_d = '0;
        end else begin
          clear_index_d = clear_index_q + 1'b1;
        end
      end
      STATE_RUN: begin
        if (clear) begin
          state_d       = STATE_CLEAR;
          clear_index_d = '0;
        end else begin
          mem_we = wr_accept;
        end
      end
      default: begin
        state_d       = STATE_CLEAR;
        clear_index_d = '0;
      end
    endcase
  end

  // Array write.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_idx] <= mem_wdata;
    end
  end

  assign ready = running;

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [ADDR_W-1:0] port_address;
    logic [DATA_W-1:0] port_word;

    assign port_address = read_address[k*ADDR_W +: ADDR_W];
    // Out-of-range addresses may alias here; the port masks them to zero.
    assign port_word    = mem_q[port_address[IDX_W-1:0]];

    register_bank_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
    ) u_read_port (
      .clock_i         (clock),
      .reset_i         (reset),
      .run_i           (running),
      .read_address_i  (port_address),
      .array_data_i    (port_word),
      .write_en_i      (wr_accept),
      .write_address_i (write_address),
      .write_data_i    (write_data),
      .read_data_o     (read_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_register_bank_param.sv
// tb/tb_register_bank_param.sv - scoreboard bench for two register bank configurations
module tb_register_bank_param;

  typedef struct packed {
    logic        ready;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset, clear, write;
  logic [4:0]  wa, ra0, ra1;
  logic [31:0] wd;
  logic [9:0]  read_address;
  logic [63:0] read_data_a, read_data_b;
  logic        ready_a, ready_b;

  assign read_address = {ra1, ra0};

  always #5 clock = ~clock;

  register_bank_param dut_a (
    .clock(clock), .reset(reset), .clear(clear), .write(write),
    .write_address(wa), .write_data(wd), .read_address(read_address),
    .read_data(read_data_a), .ready(ready_a)
  );

  register_bank_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .NUM_READ(2), .ZERO_REG(0)) dut_b (
    .clock(clock), .reset(reset), .clear(clear), .write(write),
    .write_address(wa), .write_data(wd), .read_address(read_address),
    .read_data(read_data_b), .ready(ready_b)
  );

  int checks = 0;
  int errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  // Reference model: index 0 = default bank, index 1 = DEPTH 16 / ZERO_REG 0.
  logic [31:0] mem [2][32];
  int          rem [2];
  int          depth [2] = '{32, 16};
  bit          zr [2] = '{1'b1, 1'b0};

  function automatic bit wr_eff(input int d);
    return !reset && rem[d] == 0 && !clear && write && int'(wa) < depth[d] && !(zr[d] && wa == 5'd0);
  endfunction

  function automatic logic [31:0] rd_val(input int d, input logic [4:0] a);
    if (int'(a) >= depth[d] || (zr[d] && a == 5'd0)) return 32'h0;
    if (wr_eff(d) && a == wa) return wd;
    return mem[d][a];
  endfunction

  task automatic model_edge(input int d, output exp_t e);
    e = '0;
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[d][i] = 32'h0;
      rem[d] = depth[d];
    end else if (rem[d] > 0) begin
      rem[d]--;
      e.ready = (rem[d] == 0);
    end else begin
      e.rd0   = rd_val(d, ra0);
      e.rd1   = rd_val(d, ra1);
      e.ready = !clear;
      if (clear) begin
        for (int i = 0; i < 32; i++) mem[d][i] = 32'h0;
        rem[d] = depth[d];
      end else if (wr_eff(d)) begin
        mem[d][wa] = wd;
      end
    end
  endtask

  task automatic step();
    exp_t ea, eb;
    model_edge(0, ea);
    model_edge(1, eb);
    qa.push_back(ea);
    qb.push_back(eb);
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every edge produces one response per bank; compare it against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("a_ready", {31'h0, ready_a}, {31'h0, e.ready});
      chk("a_rd0", read_data_a[31:0], e.rd0);
      chk("a_rd1", read_data_a[63:32], e.rd1);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b_ready", {31'h0, ready_b}, {31'h0, e.ready});
      chk("b_rd0", read_data_b[31:0], e.rd0);
      chk("b_rd1", read_data_b[63:32], e.rd1);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      reset = 1'b0; clear = 1'b0; write = 1'b0;
      wa = 5'($urandom_range(0, 31)); wd = $urandom;
      ra0 = 5'($urandom_range(0, 31)); ra1 = 5'($urandom_range(0, 31));
      step();
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [4:0] r0, input logic [4:0] r1);
    reset = 1'b0; clear = 1'b0; write = 1'b1; wa = a; wd = d; ra0 = r0; ra1 = r1;
    step();
  endtask

  task automatic read_all();
    for (int i = 0; i < 32; i++) begin
      reset = 1'b0; clear = 1'b0; write = 1'b0;
      ra0 = 5'(i); ra1 = 5'(31 - i);
      step();
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; write = 1'b0;
    wa = 5'd0; wd = 32'h0; ra0 = 5'd0; ra1 = 5'd0;
    step();
    idle(36);
    read_all();

    // Directed datapath cases.
    wr(5'd5, 32'hDEADBEEF, 5'd1, 5'd2);
    wr(5'd7, 32'h11111111, 5'd5, 5'd6);
    wr(5'd7, 32'h12345678, 5'd5, 5'd7);
    wr(5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    idle(0);
    reset = 1'b0; clear = 1'b0; write = 1'b0; ra0 = 5'd0; ra1 = 5'd7; step();
    wr(5'd20, 32'hCAFEF00D, 5'd1, 5'd2);
    reset = 1'b0; clear = 1'b0; write = 1'b0; ra0 = 5'd20; ra1 = 5'd20; step();

    // Populate, then clear together with a write to r3.
    for (int i = 1; i < 32; i++) wr(5'(i), $urandom, 5'(i), 5'($urandom_range(0, 31)));
    reset = 1'b0; clear = 1'b1; write = 1'b1; wa = 5'd3; wd = 32'hA5A5A5A5; ra0 = 5'd1; ra1 = 5'd2;
    step();
    idle(34);
    read_all();

    // Reset partway through the clear walk restarts it.
    reset = 1'b1; clear = 1'b0; write = 1'b0; step();
    idle(10);
    reset = 1'b1; step();
    idle(36);

    // Randomised traffic with occasional clears and resets.
    for (int i = 0; i < 2500; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      clear = ($urandom_range(0, 99) == 0);
      write = clear ? 1'b0 : 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      ra0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step();
    end
    idle(40);
    read_all();

    reset = 1'b0; clear = 1'b0; write = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d,%0d required=0,0", qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
